// File: rtl/jtkiwi_shram_arb_if.sv
// rtl/jtkiwi_shram_arb_if.sv - CPU-side bus bundle of the shared RAM arbiter
interface jtkiwi_shram_arb_if #(
  parameter int CH = 2,
  parameter int AW = 13,
  parameter int DW = 8
);
  logic              cen;
  logic [CH-1:0]     req;
  logic [CH-1:0]     we;
  logic [CH*AW-1:0]  addr;
  logic [CH*DW-1:0]  din;
  logic [DW-1:0]     dout;
  logic [CH-1:0]     ack;
  logic [CH-1:0]     wait_n;
  logic              busy;

  modport master (
    output cen, req, we, addr, din,
    input  dout, ack, wait_n, busy
  );

  modport slave (
    input  cen, req, we, addr, din,
    output dout, ack, wait_n, busy
  );
endinterface

// File: rtl/jtkiwi_shram_arb.sv
// rtl/jtkiwi_shram_arb.sv - shared RAM with round-robin or fixed-priority arbitration
// One access per IDLE->ACCESS->DONE pass; ack and read data are valid during DONE.
module jtkiwi_shram_arb #(
  parameter int CH   = 2,
  parameter int AW   = 13,
  parameter int DW   = 8,
  parameter int MODE = 0
) (
  input logic              clk,
  input logic              rstn,
  jtkiwi_shram_arb_if.slave bus
);
  localparam int PW = $clog2(CH);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state, state_nx;
  logic [CH-1:0]   armed;
  logic [CH-1:0]   pending;
  logic [PW-1:0]   last;
  logic [PW-1:0]   grant;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   idx;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   din_q;
  logic            we_q;
  logic [DW-1:0]   dout_q;
  logic [CH-1:0]   ack_q;
  logic [DW-1:0]   ram [2**AW];

  // Gating with rstn keeps wait_n at its reset value while reset is held.
  assign pending    = bus.req & armed & {CH{rstn}};
  assign bus.wait_n = ~pending;
  assign bus.busy   = (state != IDLE);
  assign bus.dout   = dout_q;
  assign bus.ack    = ack_q;

  // Walk the scan order backwards so the earliest pending channel overwrites the rest.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int i = CH; i >= 1; i--) begin
      if (MODE == 0) idx = PW'((int'(last) + i) % CH);
      else           idx = PW'(i - 1);
      if (pending[idx]) sel = idx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.cen && (|pending)) state_nx = ACCESS;
      ACCESS:  state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      armed  <= '1;
      last   <= PW'(CH - 1);
      grant  <= '0;
      addr_q <= '0;
      din_q  <= '0;
      we_q   <= 1'b0;
      dout_q <= '0;
      ack_q  <= '0;
    end else begin
      state <= state_nx;
      ack_q <= '0;
      for (int k = 0; k < CH; k++) begin
        if (state == ACCESS && grant == PW'(k)) armed[k] <= 1'b0;
        else if (!bus.req[k])                   armed[k] <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (state_nx == ACCESS) begin
            grant  <= sel;
            addr_q <= bus.addr[int'(sel)*AW +: AW];
            din_q  <= bus.din[int'(sel)*DW +: DW];
            we_q   <= bus.we[sel];
          end
        end
        ACCESS: begin
          ack_q[grant] <= 1'b1;
          if (!we_q) dout_q <= ram[addr_q];
        end
        default: begin
          if (MODE == 0) last <= grant;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ACCESS && we_q) ram[addr_q] <= din_q;
  end
endmodule

// File: tb/tb_jtkiwi_shram_arb.sv
// tb/tb_jtkiwi_shram_arb.sv - directed and randomized bench for jtkiwi_shram_arb
module tb_jtkiwi_shram_arb;
  logic clk = 1'b0;
  logic rstn;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  jtkiwi_shram_arb_if #(.CH(2), .AW(13), .DW(8)) b0 ();
  jtkiwi_shram_arb_if #(.CH(3), .AW(4),  .DW(8)) b1 ();

  jtkiwi_shram_arb #(.CH(2), .AW(13), .DW(8), .MODE(0)) dut0 (.clk(clk), .rstn(rstn), .bus(b0));
  jtkiwi_shram_arb #(.CH(3), .AW(4),  .DW(8), .MODE(1)) dut1 (.clk(clk), .rstn(rstn), .bus(b1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b0.cen = 1'b1; b0.req = '0; b0.we = '0; b0.addr = '0; b0.din = '0;
    b1.cen = 1'b1; b1.req = '0; b1.we = '0; b1.addr = '0; b1.din = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  // Single uncontended access on dut0; lat = ticks from req rise to ack, -1 on timeout.
  task automatic access0(input int ch, input bit wr, input logic [12:0] a,
                         input logic [7:0] d, output int lat);
    b0.we[ch] = wr;
    b0.addr[ch*13 +: 13] = a;
    b0.din[ch*8 +: 8] = d;
    b0.req[ch] = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick();
      if (b0.ack[ch]) lat = c;
    end
    b0.req[ch] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rstn = 1'b0;
    #1;
    total_cnt++;
    if (b0.dout !== 8'h00 || b0.ack !== 2'b00 || b0.wait_n !== 2'b11 || b0.busy !== 1'b0) begin
      $display("FAIL reset_dut0: dout=%0h ack=%b wait_n=%b busy=%b want 0/00/11/0",
               b0.dout, b0.ack, b0.wait_n, b0.busy);
    end else pass_cnt++;
    total_cnt++;
    if (b1.dout !== 8'h00 || b1.ack !== 3'b000 || b1.wait_n !== 3'b111 || b1.busy !== 1'b0) begin
      $display("FAIL reset_dut1: dout=%0h ack=%b wait_n=%b busy=%b want 0/000/111/0",
               b1.dout, b1.ack, b1.wait_n, b1.busy);
    end else pass_cnt++;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    do_reset();
    b0.we = 2'b01; b0.addr[12:0] = 13'h0123; b0.din[7:0] = 8'h5A; b0.req = 2'b01;
    #1;
    total_cnt++;
    if (b0.wait_n[0] !== 1'b0) $display("FAIL wait_n_fall: got %b want 0", b0.wait_n[0]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (b0.busy !== 1'b1 || b0.ack !== 2'b00)
      $display("FAIL wr_grant: busy=%b ack=%b want 1/00", b0.busy, b0.ack);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (b0.ack !== 2'b01 || b0.wait_n[0] !== 1'b1 || b0.dout !== 8'h00)
      $display("FAIL wr_ack: ack=%b wait_n0=%b dout=%0h want 01/1/00", b0.ack, b0.wait_n[0], b0.dout);
    else pass_cnt++;
    b0.req = 2'b00;
    tick();
    total_cnt++;
    if (b0.busy !== 1'b0 || b0.ack !== 2'b00)
      $display("FAIL wr_idle: busy=%b ack=%b want 0/00", b0.busy, b0.ack);
    else pass_cnt++;
    b0.we = 2'b00; b0.req = 2'b01;
    tick();
    tick();
    total_cnt++;
    if (b0.ack !== 2'b01 || b0.dout !== 8'h5A)
      $display("FAIL rd_ack: ack=%b dout=%0h want 01/5a", b0.ack, b0.dout);
    else pass_cnt++;
    b0.req = 2'b00;
    tick();
  endtask

  task automatic test_round_robin();
    int exp_ch, nack, maxrun;
    int run [2];
    logic [1:0] nreq;
    do_reset();
    exp_ch = 0; nack = 0; maxrun = 0; run[0] = 0; run[1] = 0;
    b0.we = 2'b00;
    b0.req = 2'b11;
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (b0.req[k] && !b0.wait_n[k]) run[k]++;
        else run[k] = 0;
        if (run[k] > maxrun) maxrun = run[k];
      end
      if (b0.ack !== 2'b00) begin
        total_cnt++;
        if (b0.ack !== (2'b01 << exp_ch))
          $display("FAIL rr_order: ack=%b want %b at ack %0d", b0.ack, 2'b01 << exp_ch, nack);
        else pass_cnt++;
        exp_ch = 1 - exp_ch;
        nack++;
      end
      nreq = b0.req;
      for (int k = 0; k < 2; k++) begin
        if (b0.ack[k]) nreq[k] = 1'b0;
        else if (!b0.req[k]) nreq[k] = 1'b1;
      end
      b0.req = nreq;
    end
    total_cnt++;
    if (nack !== 13) $display("FAIL rr_count: got %0d want 13", nack);
    else pass_cnt++;
    total_cnt++;
    if (maxrun > 6) $display("FAIL rr_wait_run: got %0d want <=6", maxrun);
    else pass_cnt++;
    b0.req = 2'b00;
    tick();
  endtask

  task automatic test_fixed_priority();
    int n0, n1, n2, got2;
    do_reset();
    n0 = 0; n1 = 0; n2 = 0; got2 = 0;
    b1.we = 3'b000;
    b1.req = 3'b101;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (b1.ack[0]) n0++;
      if (b1.ack[1]) n1++;
      if (b1.ack[2]) n2++;
      b1.req[0] = ~b1.ack[0];
    end
    total_cnt++;
    if (n2 !== 0 || n1 !== 0) $display("FAIL fp_starve: ack2=%0d ack1=%0d want 0/0", n2, n1);
    else pass_cnt++;
    total_cnt++;
    if (n0 !== 10) $display("FAIL fp_ch0_count: got %0d want 10", n0);
    else pass_cnt++;
    b1.req[0] = 1'b0;
    for (int c = 1; c <= 6 && got2 == 0; c++) begin
      tick();
      if (b1.ack[2]) got2 = c;
    end
    total_cnt++;
    if (got2 !== 2) $display("FAIL fp_ch2_served: latency %0d want 2", got2);
    else pass_cnt++;
    b1.req = 3'b000;
    tick();
  endtask

  task automatic test_cen_gate();
    int bad;
    do_reset();
    bad = 0;
    b0.cen = 1'b0;
    b0.we = 2'b00;
    b0.req = 2'b10;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (b0.ack !== 2'b00 || b0.wait_n[1] !== 1'b0 || b0.busy !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL cen_hold: %0d bad cycles want 0", bad);
    else pass_cnt++;
    b0.cen = 1'b1;
    tick();
    total_cnt++;
    if (b0.busy !== 1'b1) $display("FAIL cen_grant: busy=%b want 1", b0.busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (b0.ack !== 2'b10) $display("FAIL cen_ack: ack=%b want 10", b0.ack);
    else pass_cnt++;
    b0.req = 2'b00;
    tick();
  endtask

  task automatic test_held_request();
    int nack;
    do_reset();
    nack = 0;
    b0.we = 2'b00;
    b0.req = 2'b01;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (b0.ack[0]) nack++;
    end
    total_cnt++;
    if (nack !== 1) $display("FAIL held_once: got %0d acks want 1", nack);
    else pass_cnt++;
    b0.req = 2'b00;
    tick();
    b0.req = 2'b01;
    nack = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (b0.ack[0]) nack++;
    end
    total_cnt++;
    if (nack !== 1) $display("FAIL held_rearm: got %0d acks want 1", nack);
    else pass_cnt++;
    b0.req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int lat, bad;
    do_reset();
    access0(0, 1'b1, 13'h00AA, 8'h11, lat);
    access0(0, 1'b0, 13'h00AA, 8'h00, lat);
    total_cnt++;
    if (b0.dout !== 8'h11 || lat !== 2) $display("FAIL rst_pre: dout=%0h lat=%0d want 11/2", b0.dout, lat);
    else pass_cnt++;
    b0.we[0] = 1'b1; b0.addr[12:0] = 13'h00AA; b0.din[7:0] = 8'h77; b0.req = 2'b01;
    tick();
    rstn = 1'b0;
    #1;
    total_cnt++;
    if (b0.busy !== 1'b0 || b0.ack !== 2'b00 || b0.dout !== 8'h00 || b0.wait_n !== 2'b11)
      $display("FAIL rst_abort: busy=%b ack=%b dout=%0h wait_n=%b want 0/00/00/11",
               b0.busy, b0.ack, b0.dout, b0.wait_n);
    else pass_cnt++;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (b0.ack !== 2'b00 || b0.busy !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL rst_no_ack: %0d bad cycles want 0", bad);
    else pass_cnt++;
    b0.req = 2'b00;
    rstn = 1'b1;
    tick();
    access0(0, 1'b1, 13'h00BB, 8'h3C, lat);
    total_cnt++;
    if (lat !== 2) $display("FAIL rst_after_wr: latency %0d want 2", lat);
    else pass_cnt++;
    access0(1, 1'b0, 13'h00BB, 8'h00, lat);
    total_cnt++;
    if (lat !== 2 || b0.dout !== 8'h3C) $display("FAIL rst_after_rd: lat=%0d dout=%0h want 2/3c", lat, b0.dout);
    else pass_cnt++;
  endtask

  // Transaction-level model: RAM as an array, arbitration from the pending set at the grant edge.
  task automatic test_random();
    logic [7:0] mem [8];
    bit         act [2];
    bit         awr [2];
    logic [2:0] aa  [2];
    logic [7:0] ad  [2];
    bit         dropped [2];
    int         wcnt [2];
    logic [1:0] h1, h2, nreq;
    logic [7:0] exp_dout;
    int         rr_last, nack, maxw, lat, k, exp_k, bad_lat;
    do_reset();
    bad_lat = 0;
    for (int a = 0; a < 8; a++) begin
      mem[a] = 8'($urandom);
      access0(0, 1'b1, 13'(a), mem[a], lat);
      if (lat != 2) bad_lat++;
    end
    total_cnt++;
    if (bad_lat != 0) $display("FAIL rnd_init_latency: %0d slow writes want 0", bad_lat);
    else pass_cnt++;
    rr_last = 0; exp_dout = 8'h00; h1 = '0; h2 = '0; nack = 0; maxw = 0;
    for (int i = 0; i < 2; i++) begin act[i] = 1'b0; wcnt[i] = 0; end
    for (int c = 0; c < 300; c++) begin
      b0.cen = ($urandom_range(0, 3) != 0);
      tick();
      nreq = b0.req;
      for (int i = 0; i < 2; i++) begin
        dropped[i] = 1'b0;
        if (act[i]) begin
          wcnt[i]++;
          if (wcnt[i] > maxw) maxw = wcnt[i];
        end
      end
      if (b0.ack !== 2'b00) begin
        k = b0.ack[1] ? 1 : 0;
        exp_k = (h2 == 2'b11) ? 1 - rr_last : (h2[1] ? 1 : 0);
        total_cnt++;
        if (b0.ack !== 2'(1 << exp_k)) $display("FAIL rnd_grant: ack=%b want %b", b0.ack, 2'(1 << exp_k));
        else pass_cnt++;
        if (awr[k]) mem[aa[k]] = ad[k];
        else exp_dout = mem[aa[k]];
        total_cnt++;
        if (b0.dout !== exp_dout)
          $display("FAIL rnd_dout: ch%0d wr=%0d addr=%0d dout=%0h want %0h", k, awr[k], aa[k], b0.dout, exp_dout);
        else pass_cnt++;
        rr_last = k;
        act[k] = 1'b0;
        nreq[k] = 1'b0;
        dropped[k] = 1'b1;
        nack++;
      end
      for (int i = 0; i < 2; i++) begin
        if (!act[i] && !dropped[i] && $urandom_range(0, 2) == 0) begin
          awr[i] = 1'($urandom_range(0, 1));
          aa[i]  = 3'($urandom);
          ad[i]  = 8'($urandom);
          b0.we[i] = awr[i];
          b0.addr[i*13 +: 13] = 13'(aa[i]);
          b0.din[i*8 +: 8] = ad[i];
          nreq[i] = 1'b1;
          act[i] = 1'b1;
          wcnt[i] = 0;
        end
      end
      b0.req = nreq;
      h2 = h1;
      h1 = nreq;
    end
    total_cnt++;
    if (nack < 40) $display("FAIL rnd_ack_count: got %0d want >=40", nack);
    else pass_cnt++;
    total_cnt++;
    if (maxw > 40) $display("FAIL rnd_wait_bound: got %0d want <=40", maxw);
    else pass_cnt++;
    b0.req = 2'b00;
    b0.cen = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    rstn = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_priority();
    test_cen_gate();
    test_held_request();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
